b2b_event_merger: RTL

- Receive-side counterpart of board2board_switching: merges event streams arriving from up to TOTAL_INPUT_BOARDS other boards into one output stream for downstream cluster processing.
- Each input is the read side of an input SpyBuffer FIFO; the output drives the write side of one output SpyBuffer.
- Events are forwarded whole and never interleaved. Inputs are granted round-robin, one complete event at a time.

---
 rtl/b2b_event_merger.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/b2b_event_merger.sv
// Merges event streams from several input-board FIFOs into one output FIFO, one whole event at a time, round-robin.
// Latency: 1 cycle from FIFO head word to merged_event/merged_wren; 1 arbitration bubble between events.
// Backpressure: pops stop in the same cycle merged_almost_full is seen high; at most one word is already in flight.
module b2b_event_merger #(
    parameter int DATA_WIDTH         = 65,
    parameter int TOTAL_INPUT_BOARDS = 14,
    parameter int COUNT_WIDTH        = 32
) (
    input  logic                                           b2b_clk,
    input  logic                                           b2b_rst_n,
    input  logic [TOTAL_INPUT_BOARDS-1:0][DATA_WIDTH-1:0]  board_data,
    input  logic [TOTAL_INPUT_BOARDS-1:0]                  board_empty,
    output logic [TOTAL_INPUT_BOARDS-1:0]                  board_req,
    output logic [DATA_WIDTH-1:0]                          merged_event,
    output logic                                           merged_wren,
    input  logic                                           merged_almost_full,
    output logic [COUNT_WIDTH-1:0]                         event_count,
    output logic                                           framing_error,
    output logic [$clog2(TOTAL_INPUT_BOARDS)-1:0]          active_board
);

    localparam int unsigned N     = TOTAL_INPUT_BOARDS;
    localparam int          IDX_W = $clog2(TOTAL_INPUT_BOARDS);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    // Add an offset to a board index, wrapping at the board count (not at 2^IDX_W).
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input int unsigned      off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= N) begin
            sum = sum - N;
        end
        return sum[IDX_W-1:0];
    endfunction

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        grant_q, grant_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic                    header_seen_q, header_seen_d;
    logic [DATA_WIDTH-1:0]   merged_event_q, merged_event_d;
    logic                    merged_wren_q, merged_wren_d;
    logic [COUNT_WIDTH-1:0]  event_count_q, event_count_d;
    logic                    framing_error_q, framing_error_d;

    logic                    arb_found;
    logic [IDX_W-1:0]        arb_idx;
    logic [DATA_WIDTH-1:0]   head_word;
    logic                    head_flag;
    logic                    pop_ok;

    // The granted FIFO's head word and its metadata flag (header/footer marker).
    assign head_word = board_data[grant_q];
    assign head_flag = head_word[DATA_WIDTH-1];

    // A pop is allowed only while locked onto a non-empty input and the output has room.
    assign pop_ok = (state_q == LOCK) && !board_empty[grant_q] && !merged_almost_full;

    // Round-robin search: first non-empty input at or above the pointer, wrapping around.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!arb_found && !board_empty[wrap_add(ptr_q, k)]) begin
                arb_found = 1'b1;
                arb_idx   = wrap_add(ptr_q, k);
            end
        end
    end

    // Next-state and pop-strobe logic: grant in IDLE, stream one whole event in LOCK.
    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        ptr_d           = ptr_q;
        header_seen_d   = header_seen_q;
        merged_event_d  = merged_event_q;
        merged_wren_d   = 1'b0;
        event_count_d   = event_count_q;
        framing_error_d = framing_error_q;
        board_req       = '0;

        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    grant_d = arb_idx;
                    state_d = LOCK;
                end
            end

            LOCK: begin
                if (pop_ok) begin
                    board_req[grant_q] = 1'b1;
                    if (!header_seen_q) begin
                        if (head_flag) begin
                            // Start of event: forward the header.
                            header_seen_d  = 1'b1;
                            merged_event_d = head_word;
                            merged_wren_d  = 1'b1;
                        end else begin
                            // Orphan payload word before any header: drop it and flag it.
                            framing_error_d = 1'b1;
                        end
                    end else begin
                        merged_event_d = head_word;
                        merged_wren_d  = 1'b1;
                        if (head_flag) begin
                            // Footer closes the event; next search starts just past this input.
                            event_count_d = event_count_q + 1'b1;
                            ptr_d         = wrap_add(grant_q, 1);
                            header_seen_d = 1'b0;
                            state_d       = IDLE;
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any event in flight.
    always_ff @(posedge b2b_clk or negedge b2b_rst_n) begin
        if (!b2b_rst_n) begin
            state_q         <= IDLE;
            grant_q         <= '0;
            ptr_q           <= '0;
            header_seen_q   <= 1'b0;
            merged_event_q  <= '0;
            merged_wren_q   <= 1'b0;
            event_count_q   <= '0;
            framing_error_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            grant_q         <= grant_d;
            ptr_q           <= ptr_d;
            header_seen_q   <= header_seen_d;
            merged_event_q  <= merged_event_d;
            merged_wren_q   <= merged_wren_d;
            event_count_q   <= event_count_d;
            framing_error_q <= framing_error_d;
        end
    end

    assign merged_event  = merged_event_q;
    assign merged_wren   = merged_wren_q;
    assign event_count   = event_count_q;
    assign framing_error = framing_error_q;
    assign active_board  = grant_q;

endmodule
